tree_up_concentrator: RTL and testbench

TREE_UP_CONCENTRATOR -- requirements
Module: tree_up_concentrator

---
 rtl/tree_up_concentrator.sv | 187 ++++++++++++++++++
 tb/tb_tree_up_concentrator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_up_concentrator.sv
// Concentrates K child flit streams onto one parent link: per-VC wormhole locks,
// per-VC credits and round-robin arbitration. Optional counters: TREE_CONC_STATS_EN.
module tree_up_concentrator #(
  parameter  int unsigned K  = 4,
  parameter  int unsigned V  = 2,
  parameter  int unsigned Fw = 32,
  parameter  int unsigned B  = 4,
  localparam int unsigned Vw = (V > 1) ? $clog2(V) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [K-1:0]    child_valid,
  output logic [K-1:0]    child_ready,
  input  logic [K*Fw-1:0] child_flit,
  input  logic [K*Vw-1:0] child_vc,
  input  logic [K-1:0]    child_hdr,
  input  logic [K-1:0]    child_tail,
  output logic            out_wr,
  output logic [Fw-1:0]   out_flit,
  output logic [Vw-1:0]   out_vc,
  output logic            out_hdr,
  output logic            out_tail,
  input  logic [V-1:0]    credit_in,
  output logic            credit_err
`ifdef TREE_CONC_STATS_EN
  ,
  output logic [31:0]     flit_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int unsigned Cw  = $clog2(K);
  localparam int unsigned CRW = 4;
  localparam logic [CRW-1:0] CR_INIT = CRW'(B);

  typedef enum logic {LK_IDLE, LK_OWNED} lock_e;

  lock_e          lock_q   [V];
  lock_e          lock_d   [V];
  logic [Cw-1:0]  owner_q  [V];
  logic [Cw-1:0]  owner_d  [V];
  logic [CRW-1:0] credit_q [V];
  logic [CRW-1:0] credit_d [V];
  logic [Cw-1:0]  rr_q, rr_d;
  logic           credit_err_q, credit_err_d;
  logic           out_wr_q, out_wr_d;
  logic [Fw-1:0]  out_flit_q, out_flit_d;
  logic [Vw-1:0]  out_vc_q, out_vc_d;
  logic           out_hdr_q, out_hdr_d;
  logic           out_tail_q, out_tail_d;

  logic [Vw-1:0]  vc_c [K];
  logic [K-1:0]   elig_c;
  logic [K-1:0]   grant_c;
  logic           found_c;
  logic [Cw-1:0]  win_c;
  logic [Vw-1:0]  win_vc_c;

  // A child may move only if its VC has credit and the lock state matches its flit type.
  always_comb begin
    elig_c = '0;
    for (int unsigned c = 0; c < K; c++) begin
      vc_c[c] = child_vc[c*Vw +: Vw];
      if (child_valid[c] && (32'(vc_c[c]) < V) && (credit_q[vc_c[c]] != '0)) begin
        if (lock_q[vc_c[c]] == LK_IDLE) elig_c[c] = child_hdr[c];
        else elig_c[c] = (owner_q[vc_c[c]] == Cw'(c)) && !child_hdr[c];
      end
    end
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    logic [Cw-1:0] idx;
    idx     = '0;
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned i = 0; i < K; i++) begin
      idx = Cw'((32'(rr_q) + i) % K);
      if (!found_c && elig_c[idx]) begin
        found_c = 1'b1;
        win_c   = idx;
      end
    end
    grant_c = '0;
    if (found_c && !reset) grant_c[win_c] = 1'b1;
    win_vc_c = vc_c[win_c];
  end

  assign child_ready = grant_c;

  always_comb begin
    logic send;
    send         = 1'b0;
    lock_d       = lock_q;
    owner_d      = owner_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    rr_d         = rr_q;
    out_wr_d     = found_c;
    out_flit_d   = out_flit_q;
    out_vc_d     = out_vc_q;
    out_hdr_d    = out_hdr_q;
    out_tail_d   = out_tail_q;
    if (found_c) begin
      rr_d       = (win_c == Cw'(K-1)) ? '0 : win_c + 1'b1;
      out_flit_d = child_flit[32'(win_c)*Fw +: Fw];
      out_vc_d   = win_vc_c;
      out_hdr_d  = child_hdr[win_c];
      out_tail_d = child_tail[win_c];
      if (child_hdr[win_c] && !child_tail[win_c]) begin
        lock_d[win_vc_c]  = LK_OWNED;
        owner_d[win_vc_c] = win_c;
      end else if (!child_hdr[win_c] && child_tail[win_c]) begin
        lock_d[win_vc_c] = LK_IDLE;
      end
    end
    // Send and return in the same cycle cancel; a return into a full counter is an error.
    for (int unsigned v = 0; v < V; v++) begin
      send = found_c && (32'(win_vc_c) == v);
      if (send && !credit_in[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (!send && credit_in[v]) begin
        if (credit_q[v] >= CR_INIT) credit_err_d = 1'b1;
        else credit_d[v] = credit_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned v = 0; v < V; v++) begin
        lock_q[v]   <= LK_IDLE;
        owner_q[v]  <= '0;
        credit_q[v] <= CR_INIT;
      end
      rr_q         <= '0;
      credit_err_q <= 1'b0;
      out_wr_q     <= 1'b0;
      out_flit_q   <= '0;
      out_vc_q     <= '0;
      out_hdr_q    <= 1'b0;
      out_tail_q   <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      credit_q     <= credit_d;
      rr_q         <= rr_d;
      credit_err_q <= credit_err_d;
      out_wr_q     <= out_wr_d;
      out_flit_q   <= out_flit_d;
      out_vc_q     <= out_vc_d;
      out_hdr_q    <= out_hdr_d;
      out_tail_q   <= out_tail_d;
    end
  end

  assign out_wr     = out_wr_q;
  assign out_flit   = out_flit_q;
  assign out_vc     = out_vc_q;
  assign out_hdr    = out_hdr_q;
  assign out_tail   = out_tail_q;
  assign credit_err = credit_err_q;

`ifdef TREE_CONC_STATS_EN
  logic [31:0] flit_cnt_q, flit_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flit_cnt_d  = flit_cnt_q + 32'(out_wr_q);
    stall_cnt_d = stall_cnt_q + 32'((|child_valid) && !found_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flit_cnt  = flit_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tree_up_concentrator.sv
// Bench for tree_up_concentrator: directed scenarios plus random traffic against a
// packet-level reference model; forwarded flits are checked through a scoreboard queue.
module tb_tree_up_concentrator;
  localparam int unsigned K = 4, V = 2, FW = 32, B = 4, VW = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [K-1:0]    child_valid, child_ready, child_hdr, child_tail;
  logic [K*FW-1:0] child_flit;
  logic [K*VW-1:0] child_vc;
  logic            out_wr, out_hdr, out_tail, credit_err;
  logic [FW-1:0]   out_flit;
  logic [VW-1:0]   out_vc;
  logic [V-1:0]    credit_in;
`ifdef TREE_CONC_STATS_EN
  logic [31:0]     flit_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  tree_up_concentrator #(.K(K), .V(V), .Fw(FW), .B(B)) dut (
    .clk(clk), .reset(reset),
    .child_valid(child_valid), .child_ready(child_ready), .child_flit(child_flit),
    .child_vc(child_vc), .child_hdr(child_hdr), .child_tail(child_tail),
    .out_wr(out_wr), .out_flit(out_flit), .out_vc(out_vc), .out_hdr(out_hdr),
    .out_tail(out_tail), .credit_in(credit_in), .credit_err(credit_err)
`ifdef TREE_CONC_STATS_EN
    , .flit_cnt(flit_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [FW-1:0] flit;
    logic [VW-1:0] vc;
    logic          hdr;
    logic          tail;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: credits per VC, owning child per VC (-1 = free), next priority child.
  int m_credit[V];
  int m_owner[V];
  int m_next;
  bit m_err;
  int m_flits, m_stalls;

  // Random traffic generator state.
  bit            pk_act[K];
  int            pk_vc[K], pk_len[K], pk_pos[K];
  logic [FW-1:0] pk_data[K];
  int            occ[V];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(input int c);
    int v;
    v = int'(child_vc[c*VW +: VW]);
    return child_valid[c] && (m_credit[v] > 0) &&
           ((m_owner[v] < 0 && child_hdr[c]) || (m_owner[v] == c && !child_hdr[c]));
  endfunction

  task automatic set_child(input int c, input bit v, input int vc, input bit h, input bit t,
                           input logic [FW-1:0] d);
    child_valid[c]         = v;
    child_vc[c*VW +: VW]   = VW'(vc);
    child_hdr[c]           = h;
    child_tail[c]          = t;
    child_flit[c*FW +: FW] = d;
  endtask

  task automatic clear();
    child_valid = '0;
    child_hdr   = '0;
    child_tail  = '0;
    credit_in   = '0;
  endtask

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_credit[v] = B;
      m_owner[v]  = -1;
      occ[v]      = 0;
    end
    m_next   = 0;
    m_err    = 1'b0;
    m_flits  = 0;
    m_stalls = 0;
    exp_q.delete();
  endtask

  // One cycle: called just after a falling edge with inputs set; returns at the next one.
  task automatic step(input int exp_rdy, output int win);
    logic [K-1:0] rdy;
    int wv;
    #1;
    win = -1;
    for (int i = 0; i < K; i++) begin
      int c;
      c = (m_next + i) % K;
      if (win < 0 && elig(c)) win = c;
    end
    rdy = '0;
    if (win >= 0) rdy[win] = 1'b1;
    chk("child_ready", 64'(child_ready), 64'(rdy));
    if (exp_rdy >= 0) chk("directed_ready", 64'(child_ready), 64'(exp_rdy));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    wv = -1;
    if (win >= 0) begin
      exp_t e;
      wv     = int'(child_vc[win*VW +: VW]);
      e.flit = child_flit[win*FW +: FW];
      e.vc   = VW'(wv);
      e.hdr  = child_hdr[win];
      e.tail = child_tail[win];
      exp_q.push_back(e);
      m_flits++;
      m_next = (win + 1) % K;
      if (e.hdr && !e.tail) m_owner[wv] = win;
      else if (!e.hdr && e.tail) m_owner[wv] = -1;
    end else if (|child_valid) begin
      m_stalls++;
    end
    for (int v = 0; v < V; v++) begin
      if (wv == v && !credit_in[v]) m_credit[v]--;
      else if (wv != v && credit_in[v]) begin
        if (m_credit[v] == B) m_err = 1'b1;
        else m_credit[v]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #3;
    set_child(0, 1'b1, 0, 1'b1, 1'b1, 32'hdead_beef);
    reset = 1'b1;
    #1;
    chk("rst_out_wr", 64'(out_wr), 64'(0));
    chk("rst_out_flit", 64'(out_flit), 64'(0));
    chk("rst_out_vc", 64'(out_vc), 64'(0));
    chk("rst_out_hdr", 64'(out_hdr), 64'(0));
    chk("rst_out_tail", 64'(out_tail), 64'(0));
    chk("rst_child_ready", 64'(child_ready), 64'(0));
    chk("rst_credit_err", 64'(credit_err), 64'(0));
    clear();
    model_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every forwarded flit must match the oldest expected one, one cycle after grant.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (out_wr === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_wr", 64'(out_wr), 64'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_flit", 64'(out_flit), 64'(e.flit));
            chk("out_vc", 64'(out_vc), 64'(e.vc));
            chk("out_hdr", 64'(out_hdr), 64'(e.hdr));
            chk("out_tail", 64'(out_tail), 64'(e.tail));
          end
        end else begin
          chk("out_wr", 64'(out_wr), 64'(exp_q.size() != 0));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    child_flit = '0;
    child_vc = '0;
    clear();
    model_reset();

    // Three-flit packet on VC0 from child 0 leaves one credit.
    do_reset();
    set_child(0, 1, 0, 1, 0, $urandom); step(4'b0001, w);
    set_child(0, 1, 0, 0, 0, $urandom); step(4'b0001, w);
    set_child(0, 1, 0, 0, 1, $urandom); step(4'b0001, w);
    clear(); step(0, w);
    set_child(0, 1, 0, 1, 1, $urandom); step(4'b0001, w);
    set_child(0, 1, 0, 1, 1, $urandom); step(0, w);
    clear(); step(0, w);

    // Two headers on VC1: child 1 wins, child 2 waits for child 1's tail.
    do_reset();
    set_child(1, 1, 1, 1, 0, $urandom); set_child(2, 1, 1, 1, 1, $urandom); step(4'b0010, w);
    set_child(1, 1, 1, 0, 0, $urandom); step(4'b0010, w);
    set_child(1, 1, 1, 0, 1, $urandom); step(4'b0010, w);
    child_valid[1] = 1'b0; step(4'b0100, w);
    clear(); step(0, w);

    // Credit exhaustion and a single credit return.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_child(0, 1, 0, 1, 1, $urandom); step(4'b0001, w);
    end
    set_child(0, 1, 0, 1, 1, $urandom); step(0, w);
    step(0, w);
    credit_in[0] = 1'b1; step(0, w);
    credit_in[0] = 1'b0; step(4'b0001, w);
    clear(); step(0, w);

    // Credit return into a full counter: sticky error, counter stays at B.
    do_reset();
    credit_in[1] = 1'b1; step(0, w);
    credit_in[1] = 1'b0;
    chk("credit_err_set", 64'(credit_err), 64'(1));
    repeat (3) step(0, w);
    chk("credit_err_sticky", 64'(credit_err), 64'(1));
    for (int i = 0; i < 4; i++) begin
      set_child(2, 1, 1, 1, 1, $urandom); step(4'b0100, w);
    end
    set_child(2, 1, 1, 1, 1, $urandom); step(0, w);
    clear(); step(0, w);

    // Reset in the middle of a VC0 packet frees the lock.
    do_reset();
    set_child(0, 1, 0, 1, 0, $urandom); step(4'b0001, w);
    set_child(0, 1, 0, 0, 0, $urandom); step(4'b0001, w);
    do_reset();
    set_child(3, 1, 0, 1, 1, $urandom); step(4'b1000, w);
    clear(); step(0, w);

    // Random multi-child, multi-VC traffic with parent credit returns.
    do_reset();
    for (int c = 0; c < K; c++) begin
      pk_act[c]  = 1'b0;
      pk_data[c] = $urandom;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < K; c++) begin
        if (!pk_act[c] && $urandom_range(2) == 0) begin
          pk_act[c] = 1'b1;
          pk_vc[c]  = int'($urandom_range(V-1));
          pk_len[c] = int'($urandom_range(4, 1));
          pk_pos[c] = 0;
        end
        if (pk_act[c])
          set_child(c, $urandom_range(3) != 0, pk_vc[c], pk_pos[c] == 0,
                    pk_pos[c] == pk_len[c] - 1, pk_data[c]);
        else
          set_child(c, $urandom_range(7) == 0, int'($urandom_range(V-1)), 1'b0,
                    1'($urandom_range(1)), $urandom);
      end
      for (int v = 0; v < V; v++) credit_in[v] = (occ[v] > 0) && ($urandom_range(2) == 0);
      step(-1, w);
      for (int v = 0; v < V; v++) if (credit_in[v]) occ[v]--;
      if (w >= 0) begin
        occ[int'(child_vc[w*VW +: VW])]++;
        if (pk_act[w]) begin
          pk_pos[w]++;
          pk_data[w] = $urandom;
          if (pk_pos[w] == pk_len[w]) pk_act[w] = 1'b0;
        end
      end
    end
    clear();
    step(0, w);
    step(0, w);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
`ifdef TREE_CONC_STATS_EN
    chk("flit_cnt", 64'(flit_cnt), 64'(m_flits));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
